// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep pipelined add/subtract with valid/ready flow control.
// Each stage adds one CW-bit chunk; unconsumed operands and finished chunks ride along.
`default_nettype none

module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             en;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             ovf_d;

    // Only a held, unconsumed result can freeze the pipe.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int REM  = WIDTH - k * CW;
            localparam int DONE = (k + 1) * CW;

            logic [REM-1:0]  a_in;
            logic [REM-1:0]  b_in;
            logic            cin;
            logic            m_in;
            logic            v_in;
            logic [CW-1:0]   bx;
            logic [CW:0]     part;
            logic [DONE-1:0] s_out;

            if (k == 0) begin : g_head
                assign a_in  = a;
                assign b_in  = b;
                assign cin   = mode | ci;
                assign m_in  = mode;
                assign v_in  = in_valid;
                assign s_out = part[CW-1:0];
            end else begin : g_body
                logic [REM-1:0]    a_q;
                logic [REM-1:0]    b_q;
                logic [k*CW-1:0]   s_q;
                logic              c_q;
                logic              m_q;
                logic              v_q;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                        s_q <= '0;
                        c_q <= 1'b0;
                        m_q <= 1'b0;
                        v_q <= 1'b0;
                    end else if (en) begin
                        a_q <= g_stage[k-1].a_in[REM+CW-1:CW];
                        b_q <= g_stage[k-1].b_in[REM+CW-1:CW];
                        s_q <= g_stage[k-1].s_out;
                        c_q <= g_stage[k-1].part[CW];
                        m_q <= g_stage[k-1].m_in;
                        v_q <= g_stage[k-1].v_in;
                    end
                end

                assign a_in  = a_q;
                assign b_in  = b_q;
                assign cin   = c_q;
                assign m_in  = m_q;
                assign v_in  = v_q;
                assign s_out = {part[CW-1:0], s_q};
            end

            assign bx   = m_in ? ~b_in[CW-1:0] : b_in[CW-1:0];
            assign part = {1'b0, a_in[CW-1:0]} + {1'b0, bx} + {{CW{1'b0}}, cin};
        end
    endgenerate

    // Signed overflow from the MSB chunk of the last stage, using the effective B.
    assign ovf_d = (g_stage[LAST].a_in[CW-1] == g_stage[LAST].bx[CW-1]) &&
                   (g_stage[LAST].part[CW-1] != g_stage[LAST].a_in[CW-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= g_stage[LAST].v_in;
            sum_q       <= g_stage[LAST].s_out;
            co_q        <= g_stage[LAST].part[CW];
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed checks of pipe_adder against an arithmetic model.
`default_nettype none

module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [7:0] a8, b8, sum8;
    logic       ci8, mode8, iv8, ir8, ov8, or8, co8, ovf8;
    logic [2:0] a3, b3, sum3;
    logic       ci3, mode3, iv3, ir3, ov3, or3, co3, ovf3;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .ci(ci8), .mode(mode8),
        .in_valid(iv8), .in_ready(ir8), .sum(sum8), .co(co8), .ovf(ovf8),
        .out_valid(ov8), .out_ready(or8)
    );

    pipe_adder #(.WIDTH(3), .STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .a(a3), .b(b3), .ci(ci3), .mode(mode3),
        .in_valid(iv3), .in_ready(ir3), .sum(sum3), .co(co3), .ovf(ovf3),
        .out_valid(ov3), .out_ready(or3)
    );

    logic [31:0] pack8, pack3;
    assign pack8 = {22'b0, ovf8, co8, sum8};
    assign pack3 = {27'b0, ovf3, co3, sum3};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Result packed as {ovf, co, sum[w-1:0]}
    function automatic int model(input int w, input int a, input int b, input int ci, input int m);
        int mask, bb, t, s, c, sa, sb, ss, ov;
        mask = (1 << w) - 1;
        bb   = m ? (~b & mask) : b;
        t    = a + bb + (m ? 1 : ci);
        s    = t & mask;
        c    = (t >> w) & 1;
        sa   = (a >> (w - 1)) & 1;
        sb   = (bb >> (w - 1)) & 1;
        ss   = (s >> (w - 1)) & 1;
        ov   = (sa == sb && ss != sa) ? 1 : 0;
        return (ov << (w + 1)) | (c << w) | s;
    endfunction

    int          sb8[$];
    int          exp3[$];
    int          acc3[$];
    int          cyc = 0;
    int          n3_out = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_out = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(ov8), 32'd1);
                check("stall_hold", pack8, prev_out);
            end
            if (ov8 && or8) begin
                if (sb8.size() == 0) check("sb8_extra", 32'(ov8), 32'd0);
                else check("sb8_data", pack8, 32'(sb8.pop_front()));
            end
            if (iv8 && ir8)
                sb8.push_back(model(8, int'(a8), int'(b8), int'(ci8), int'(mode8)));
            prev_stall = ov8 && !or8;
            prev_out   = pack8;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ov3 && or3) begin
                n3_out++;
                if (exp3.size() == 0) begin
                    check("sb3_extra", 32'(ov3), 32'd0);
                end else begin
                    check("sb3_data", pack3, 32'(exp3.pop_front()));
                    check("sb3_latency", 32'(cyc - acc3.pop_front()), 32'd3);
                end
            end
            if (iv3 && ir3) begin
                exp3.push_back(model(3, int'(a3), int'(b3), int'(ci3), int'(mode3)));
                acc3.push_back(cyc);
            end
        end
    end

    task automatic single8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic m, input logic [7:0] es, input logic ec,
                           input logic eo, input string tag);
        @(posedge clk); #1;
        a8 = a; b8 = b; ci8 = c; mode8 = m; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 32'(ov8), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(ov8), 32'd1);
        check({tag, "_res"}, pack8, {22'b0, eo, ec, es});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a8 = '0; b8 = '0; ci8 = 1'b0; mode8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        a3 = '0; b3 = '0; ci3 = 1'b0; mode3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_in_ready8", 32'(ir8), 32'd1);
        check("rst_out_valid3", 32'(ov3), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(ir8), 32'd1);

        single8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
        single8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
        single8(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, "sub_noborrow");
        single8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");
        single8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
        single8(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "add_ci");

        // Back-pressure: three back-to-back ops, 3-cycle stall on first result
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; mode8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h33; b8 = 8'h11; mode8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hC0; b8 = 8'h50; ci8 = 1'b1; mode8 = 1'b0; or8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(ov8), 32'd1);
            check("bp_in_ready", 32'(ir8), 32'd0);
            check("bp_hold", pack8, 32'h030);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        @(negedge clk);
        check("bp_out1", 32'(ov8), 32'd1);
        check("bp_accept3", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(negedge clk);
        check("bp_out2", 32'(ov8), 32'd1);
        @(negedge clk);
        check("bp_out3", 32'(ov8), 32'd1);
        @(negedge clk);
        check("bp_idle", 32'(ov8), 32'd0);

        // Randomized traffic with random back-pressure
        repeat (400) begin
            @(posedge clk); #1;
            iv8   = ($urandom_range(0, 3) != 0);
            a8    = 8'($urandom);
            b8    = 8'($urandom);
            ci8   = 1'($urandom);
            mode8 = 1'($urandom);
            or8   = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1;
        repeat (10) @(posedge clk);
        check("drain8", 32'(sb8.size()), 32'd0);

        // Reset with two operations in flight
        @(posedge clk); #1;
        a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; mode8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h03; b8 = 8'h04;
        @(negedge clk); #2;
        reset = 1'b1;
        sb8.delete();
        #1;
        check("rst_mid_valid", 32'(ov8), 32'd0);
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(negedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", 32'(ov8), 32'd0);
            check("rst_mid_ready", 32'(ir8), 32'd1);
        end

        // Reset while a result is presented: clears without a clock edge
        @(posedge clk); #1;
        a8 = 8'h55; b8 = 8'h22; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_async_pre", 32'(ov8), 32'd1);
        #2;
        reset = 1'b1;
        sb8.delete();
        #1;
        check("rst_async_clear", 32'(ov8), 32'd0);
        check("rst_async_ready", 32'(ir8), 32'd1);
        @(negedge clk); #2;
        reset = 1'b0;
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_async_quiet", 32'(ov8), 32'd0);
        end

        // Exhaustive WIDTH=3, STAGES=3, one op per cycle
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    for (int c = 0; c < 2; c++) begin
                        @(posedge clk); #1;
                        a3 = 3'(a); b3 = 3'(b); ci3 = 1'(c); mode3 = 1'(m); iv3 = 1'b1;
                    end
        @(posedge clk); #1;
        iv3 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("drain3", 32'(exp3.size()), 32'd0);
        check("count3", 32'(n3_out), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width in bits (>= 2).
REQ-002 The block SHALL have parameter STAGES, default 2: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; CW = WIDTH/STAGES bits are added per stage.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port ci, input, 1 bit: carry-in; used in add mode only.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result.
REQ-012 The block SHALL have port co, output, 1 bit: carry-out; in subtract mode, 1 = no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid, output, 1 bit: sum/co/ovf are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-016 Add mode SHALL produce {co,sum} = a + b + ci, computed modulo 2^(WIDTH+1).
REQ-017 Subtract mode SHALL produce {co,sum} = a + ~b + 1, ignoring ci.
REQ-018 ovf SHALL be 1 when both effective operand MSBs are equal and the sum MSB differs from them; the effective B is ~b in subtract mode.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add operand bits [k*CW +: CW] plus the registered carry from stage k-1; stage 0 SHALL take the carry from ci, or from 1 in subtract mode.
REQ-020 Operand bits not yet consumed SHALL be skew-delayed alongside the data; completed low result chunks SHALL be delayed so that all WIDTH bits emerge together.
REQ-021 Each stage SHALL carry its own valid bit, with mode captured at acceptance.
REQ-022 The pipeline enable SHALL be en = !(out_valid && !out_ready); all stage registers SHALL advance only when en = 1.
REQ-023 in_ready SHALL equal en; an operand set SHALL be accepted on a cycle where in_valid && in_ready.
REQ-024 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, absent stalls.
REQ-025 Throughput SHALL be one operation per cycle while out_ready = 1.
REQ-026 While a stall is in effect, sum/co/ovf/out_valid SHALL hold constant, no data SHALL be lost or duplicated, and results SHALL keep input order.
REQ-027 A bubble (in_valid = 0 while en = 1) SHALL propagate as a stage valid bit of 0.
REQ-028 out_valid = 0 SHALL never cause a stall.
REQ-029 With STAGES = 1, the block SHALL degenerate to a single registered adder with latency 1.
REQ-030 Values on sum/co/ovf while out_valid = 0 are don't-care; a bench SHALL NOT check them.

Reset
REQ-031 Asserting reset SHALL immediately clear all stage valid bits, out_valid, sum, co, ovf and all pipeline data registers to 0, independent of clk.
REQ-032 After reset, in_ready SHALL be 1.
REQ-033 Operations in flight when reset is asserted SHALL be discarded and never emitted.
REQ-034 The first acceptance SHALL occur on the first rising edge after reset deasserts with in_valid = 1.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-035 Add wrap: a=FF, b=01, ci=0, mode=0 -> after 2 cycles out_valid=1, sum=00, co=1, ovf=0.
REQ-036 Subtract borrow: a=05, b=07, mode=1 -> sum=FE, co=0, ovf=0; and a=07, b=05 -> sum=02, co=1.
REQ-037 Signed overflow: a=7F, b=01, ci=0, add -> sum=80, co=0, ovf=1; and a=80, b=01, subtract -> sum=7F, ovf=1.
REQ-038 Back-pressure: three back-to-back operations with out_ready=0 from the first out_valid for 3 cycles -> in_ready=0 during the stall, first result held stable, then all three results in order on consecutive cycles.
REQ-039 Reset mid-flight: two operations accepted, reset pulsed before the first emerges -> out_valid=0 immediately and stays 0; in_ready=1 after release.
REQ-040 Exhaustive: WIDTH=3, STAGES=3, all a, b, ci in both modes, one per cycle, out_ready=1 -> every result matches the behavioural model, with latency 3 and no gaps.
